serial_host: RTL and testbench
==============================

SERIAL_HOST -- requirements
Module: serial_host

Interface
REQ-001 SHALL have parameters: CLK_RATE, default 50, input clock in MHz; BAUD, default 115200, UART bit rate; TIMEOUT_CYC, default 50_000_000, maximum cycles spent waiting for any received word.
REQ-002 SHALL have one clock and a synchronous, active-high reset.
REQ-003 Ports:
clk  in  1  sole clock
reset  in  1  synchronous active-high reset
srx  in  1  serial line from target
stx  out  1  serial line to target
req_valid  in  1  command request
req_ready  out  1  block can accept a request
req_cmd  in  4  debug command code
req_addr  in  32  target address
req_data  in  32  write data (don't-care for reads, still sent)
resp_valid  out  1  one-cycle response strobe
resp_data  out  32  reply word from target
resp_err  out  2  00 ok, 01 echo mismatch, 10 timeout
busy  out  1  transaction in progress (= !req_ready)

Function
REQ-004 SHALL initiate one transaction: cmd word, addr word, data word, with each word echo-checked, followed by one reply word.
REQ-005 SHALL encode the cmd word on the line as {28'b0, req_cmd}; addr and data SHALL be sent unmodified; word serialization SHALL match uart_tx_word/uart_rx_word.
REQ-006 SHALL assert req_ready only in S_IDLE; a request is accepted on the cycle where req_valid && req_ready, and cmd/addr/data are latched on that cycle.
REQ-007 State machine: S_IDLE -> S_SEND_CMD -> S_WAIT_CMD_ECHO -> S_SEND_ADDR -> S_WAIT_ADDR_ECHO -> S_SEND_DATA -> S_WAIT_DATA_ECHO -> S_WAIT_REPLY -> S_IDLE.
REQ-008 Each S_SEND_x state SHALL pulse tx start for exactly one cycle on entry, then remain until tx idle is observed with start low, then advance.
REQ-009 Each wait state SHALL advance on the rx-ready pulse, comparing rx_word to the latched sent word (echo states) or capturing it (S_WAIT_REPLY).
REQ-010 An echo mismatch SHALL set a sticky error of 01 and SHALL NOT abort; the sequence continues so both ends stay in lockstep.
REQ-011 A 32-bit wait counter SHALL clear on entry to every wait state, increment each cycle in it, and on reaching TIMEOUT_CYC SHALL return to S_IDLE with resp_valid=1, resp_err=10, resp_data=0.
REQ-012 Timeout SHALL take precedence over mismatch; rx-ready arriving on the timeout cycle SHALL be ignored.
REQ-013 On rx-ready in S_WAIT_REPLY, resp_data SHALL take rx_word and resp_valid SHALL pulse for exactly one cycle on the S_WAIT_REPLY -> S_IDLE transition, with resp_err = sticky error.
REQ-014 resp_data and resp_err SHALL hold until the next response; the sticky error SHALL clear on request accept.
REQ-015 rx-ready pulses in S_IDLE or S_SEND_x states SHALL be discarded without state change.
REQ-016 req_valid while busy SHALL be ignored (not queued); a new request is acceptable on the cycle after resp_valid.

Reset
REQ-017 On reset: state S_IDLE, req_ready=1, busy=0, resp_valid=0, resp_data=0, resp_err=00, tx start=0, wait counter=0, sticky error=00, latches 0.
REQ-018 Reset mid-transaction SHALL abort without emitting resp_valid; the tx and rx instances SHALL receive reset so stx returns idle-high.

Structure
REQ-019 A shared package SHALL hold the state enum (4-bit), the command-code constants, and the resp_err encodings, shared with the target-side decoder.
REQ-020 SHALL instantiate the existing uart_tx_word and uart_rx_word with the CLK_RATE/BAUD parameters passed through; no new sub-module.

Verification
REQ-021 Loopback to a target-side decoder model: req cmd=4'h2, addr=32'h0000_1000, data=32'hDEAD_BEEF, model reply 32'h1234_5678 -> one resp_valid, resp_data=32'h1234_5678, resp_err=00.
REQ-022 Model corrupts addr echo to 32'h0000_1001 -> sequence completes, resp_err=01, resp_data=reply word.
REQ-023 TIMEOUT_CYC=1000, model silent after cmd echo -> resp_valid exactly 1000 cycles after S_WAIT_ADDR_ECHO entry, resp_err=10, resp_data=0, req_ready=1 the next cycle.
REQ-024 reset asserted during S_SEND_DATA -> no resp_valid, stx high within one cycle, next request completes with resp_err=00.
REQ-025 req_valid held high during a transaction with different fields -> ignored; only the first request's words appear on stx.
REQ-026 Spurious rx word injected in S_IDLE -> discarded; next transaction resp_err=00.

Source files
------------

// File: rtl/serial_host_pkg.sv
// Shared definitions for the serial debug host and the target-side decoder:
// FSM state codes, command codes, response error codes and small helpers.
package serial_host_pkg;

  typedef logic [3:0] state_t;

  localparam state_t S_IDLE           = 4'd0;
  localparam state_t S_SEND_CMD       = 4'd1;
  localparam state_t S_WAIT_CMD_ECHO  = 4'd2;
  localparam state_t S_SEND_ADDR      = 4'd3;
  localparam state_t S_WAIT_ADDR_ECHO = 4'd4;
  localparam state_t S_SEND_DATA      = 4'd5;
  localparam state_t S_WAIT_DATA_ECHO = 4'd6;
  localparam state_t S_WAIT_REPLY     = 4'd7;

  localparam logic [3:0] CMD_NOP    = 4'h0;
  localparam logic [3:0] CMD_READ   = 4'h1;
  localparam logic [3:0] CMD_WRITE  = 4'h2;
  localparam logic [3:0] CMD_HALT   = 4'h3;
  localparam logic [3:0] CMD_RESUME = 4'h4;

  localparam logic [1:0] ERR_OK      = 2'b00;
  localparam logic [1:0] ERR_ECHO    = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT = 2'b10;

  // Clock cycles per UART bit; clk_mhz is the clock rate in MHz.
  function automatic int unsigned baud_div(input int unsigned clk_mhz, input int unsigned baud);
    longint unsigned hz;
    hz = longint'(clk_mhz) * 64'd1_000_000;
    return int'(hz / longint'(baud));
  endfunction

  function automatic state_t next_state(input state_t s);
    case (s)
      S_IDLE:           return S_SEND_CMD;
      S_SEND_CMD:       return S_WAIT_CMD_ECHO;
      S_WAIT_CMD_ECHO:  return S_SEND_ADDR;
      S_SEND_ADDR:      return S_WAIT_ADDR_ECHO;
      S_WAIT_ADDR_ECHO: return S_SEND_DATA;
      S_SEND_DATA:      return S_WAIT_DATA_ECHO;
      S_WAIT_DATA_ECHO: return S_WAIT_REPLY;
      default:          return S_IDLE;
    endcase
  endfunction

endpackage

// File: rtl/serial_host_uart.sv
// Word-level UART: a 32-bit word travels as four 8N1 bytes, least significant
// byte first, each byte least significant bit first.
module uart_tx_word
  import serial_host_pkg::*;
#(
  parameter int unsigned CLK_RATE = 50,
  parameter int unsigned BAUD     = 115200
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] word,
  output logic        line,
  output logic        idle
);
  localparam int unsigned DIV = baud_div(CLK_RATE, BAUD);
  localparam int CW = $clog2(DIV);

  logic          busy;
  logic [CW-1:0] baud_cnt;
  logic [3:0]    bit_cnt;
  logic [1:0]    byte_cnt;
  logic [9:0]    frame;
  logic [31:0]   word_sr;

  // NOTE: every register here is updated with <= so all of them see the
  // pre-edge values of each other, exactly like the flops they become.
  always_ff @(posedge clk) begin
    if (reset) begin
      busy     <= 1'b0;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      byte_cnt <= '0;
      frame    <= '1;
      word_sr  <= '0;
    end else if (!busy) begin
      if (start) begin
        busy     <= 1'b1;
        baud_cnt <= '0;
        bit_cnt  <= '0;
        byte_cnt <= '0;
        frame    <= {1'b1, word[7:0], 1'b0};
        word_sr  <= {8'h00, word[31:8]};
      end
    end else if (baud_cnt == CW'(DIV - 1)) begin
      baud_cnt <= '0;
      if (bit_cnt == 4'd9) begin
        bit_cnt <= '0;
        if (byte_cnt == 2'd3) begin
          busy  <= 1'b0;
          frame <= '1;
        end else begin
          byte_cnt <= byte_cnt + 2'd1;
          frame    <= {1'b1, word_sr[7:0], 1'b0};
          word_sr  <= {8'h00, word_sr[31:8]};
        end
      end else begin
        bit_cnt <= bit_cnt + 4'd1;
        frame   <= {1'b1, frame[9:1]};
      end
    end else begin
      baud_cnt <= baud_cnt + 1'b1;
    end
  end

  // frame[0] idles at 1, so the line comes straight from a flop.
  assign line = frame[0];
  assign idle = !busy;
endmodule

module uart_rx_word
  import serial_host_pkg::*;
#(
  parameter int unsigned CLK_RATE = 50,
  parameter int unsigned BAUD     = 115200
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        line,
  output logic        ready,
  output logic [31:0] word
);
  localparam int unsigned DIV = baud_div(CLK_RATE, BAUD);
  localparam int CW = $clog2(DIV);

  logic          sync1, sync2;
  logic          active;
  logic [CW-1:0] baud_cnt;
  logic [3:0]    bit_cnt;
  logic [1:0]    byte_cnt;
  logic [7:0]    byte_sr;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1    <= 1'b1;
      sync2    <= 1'b1;
      active   <= 1'b0;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      byte_cnt <= '0;
      byte_sr  <= '0;
      word     <= '0;
      ready    <= 1'b0;
    end else begin
      sync1 <= line;
      sync2 <= sync1;
      ready <= 1'b0;
      if (!active) begin
        if (!sync2) begin
          // Preloading half a bit puts every later sample near mid-bit.
          active   <= 1'b1;
          baud_cnt <= CW'(DIV / 2);
          bit_cnt  <= '0;
        end
      end else if (baud_cnt == CW'(DIV - 1)) begin
        baud_cnt <= '0;
        if (bit_cnt == 4'd0) begin
          if (sync2) active <= 1'b0;
          else       bit_cnt <= 4'd1;
        end else if (bit_cnt == 4'd9) begin
          active   <= 1'b0;
          word     <= {byte_sr, word[31:8]};
          byte_cnt <= byte_cnt + 2'd1;
          if (byte_cnt == 2'd3) ready <= 1'b1;
        end else begin
          byte_sr <= {sync2, byte_sr[7:1]};
          bit_cnt <= bit_cnt + 4'd1;
        end
      end else begin
        baud_cnt <= baud_cnt + 1'b1;
      end
    end
  end
endmodule

// File: rtl/serial_host.sv
// Debug host: sends cmd/addr/data words to a target over UART, checks each
// echo, then returns the target's reply word (or a timeout) as a response.
module serial_host
  import serial_host_pkg::*;
#(
  parameter int unsigned CLK_RATE    = 50,
  parameter int unsigned BAUD        = 115200,
  parameter int unsigned TIMEOUT_CYC = 50_000_000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        srx,
  output logic        stx,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [3:0]  req_cmd,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_data,
  output logic        resp_valid,
  output logic [31:0] resp_data,
  output logic [1:0]  resp_err,
  output logic        busy
);
  localparam logic [31:0] TIMEOUT_LAST = 32'(TIMEOUT_CYC - 1);

  state_t      state;
  logic        tx_start;
  logic [31:0] tx_word;
  logic [31:0] addr_q, data_q;
  logic [31:0] wait_cnt;
  logic [1:0]  sticky_err;
  logic        tx_idle;
  logic        rx_ready;
  logic [31:0] rx_word;

  uart_tx_word #(.CLK_RATE(CLK_RATE), .BAUD(BAUD)) u_tx (
    .clk   (clk),
    .reset (reset),
    .start (tx_start),
    .word  (tx_word),
    .line  (stx),
    .idle  (tx_idle)
  );

  uart_rx_word #(.CLK_RATE(CLK_RATE), .BAUD(BAUD)) u_rx (
    .clk   (clk),
    .reset (reset),
    .line  (srx),
    .ready (rx_ready),
    .word  (rx_word)
  );

  // Holding off during the response cycle makes the next accept land one
  // cycle after resp_valid even if req_valid never drops.
  assign req_ready = (state == S_IDLE) && !resp_valid;
  assign busy      = !req_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      tx_start   <= 1'b0;
      tx_word    <= '0;
      addr_q     <= '0;
      data_q     <= '0;
      wait_cnt   <= '0;
      sticky_err <= ERR_OK;
      resp_valid <= 1'b0;
      resp_data  <= '0;
      resp_err   <= ERR_OK;
    end else begin
      resp_valid <= 1'b0;
      tx_start   <= 1'b0;
      case (state)
        S_IDLE: begin
          if (req_valid && req_ready) begin
            tx_word    <= {28'b0, req_cmd};
            addr_q     <= req_addr;
            data_q     <= req_data;
            sticky_err <= ERR_OK;
            tx_start   <= 1'b1;
            state      <= S_SEND_CMD;
          end
        end
        S_SEND_CMD, S_SEND_ADDR, S_SEND_DATA: begin
          // tx_idle is still high on the start cycle; wait for it to drop first.
          if (!tx_start && tx_idle) begin
            wait_cnt <= '0;
            state    <= next_state(state);
          end
        end
        S_WAIT_CMD_ECHO, S_WAIT_ADDR_ECHO, S_WAIT_DATA_ECHO, S_WAIT_REPLY: begin
          wait_cnt <= wait_cnt + 32'd1;
          if (wait_cnt == TIMEOUT_LAST) begin
            state      <= S_IDLE;
            resp_valid <= 1'b1;
            resp_data  <= '0;
            resp_err   <= ERR_TIMEOUT;
          end else if (rx_ready) begin
            if (state == S_WAIT_REPLY) begin
              state      <= S_IDLE;
              resp_valid <= 1'b1;
              resp_data  <= rx_word;
              resp_err   <= sticky_err;
            end else begin
              // A bad echo is only recorded; both ends must stay in step.
              if (rx_word != tx_word) sticky_err <= ERR_ECHO;
              state <= next_state(state);
              if (state == S_WAIT_DATA_ECHO) begin
                wait_cnt <= '0;
              end else begin
                tx_start <= 1'b1;
                tx_word  <= (state == S_WAIT_CMD_ECHO) ? addr_q : data_q;
              end
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_serial_host.sv
// Self-checking bench: a behavioural target decoder on stx/srx plus a
// response scoreboard, driven from a vector table and hand-written sequences.
module tb_serial_host;
  import serial_host_pkg::*;

  localparam int unsigned CLK_RATE = 1;
  localparam int unsigned BAUD     = 250_000;
  localparam int          DIV      = 4;
  localparam int unsigned TIMEOUT  = 1000;

  logic        clk = 1'b0;
  logic        reset;
  logic        srx;
  logic        stx;
  logic        req_valid;
  logic        req_ready;
  logic [3:0]  req_cmd;
  logic [31:0] req_addr;
  logic [31:0] req_data;
  logic        resp_valid;
  logic [31:0] resp_data;
  logic [1:0]  resp_err;
  logic        busy;

  serial_host #(.CLK_RATE(CLK_RATE), .BAUD(BAUD), .TIMEOUT_CYC(TIMEOUT)) dut (
    .clk        (clk),
    .reset      (reset),
    .srx        (srx),
    .stx        (stx),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_cmd    (req_cmd),
    .req_addr   (req_addr),
    .req_data   (req_data),
    .resp_valid (resp_valid),
    .resp_data  (resp_data),
    .resp_err   (resp_err),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    logic [1:0]  err;
  } exp_t;

  typedef struct {
    logic [3:0]  cmd;
    logic [31:0] addr;
    logic [31:0] data;
    logic [31:0] reply;
    int          corrupt;   // index of the echo to corrupt, -1 for none
  } vec_t;

  exp_t sb[$];
  exp_t mon_e;
  int   total  = 0;
  int   passed = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
    else passed++;
  endtask

  // Response monitor: every resp_valid must match the oldest expectation.
  always @(negedge clk) begin
    if (!reset && resp_valid) begin
      if (sb.size() == 0) begin
        check("resp_valid_unexpected", {31'b0, resp_valid}, 32'd0);
      end else begin
        mon_e = sb.pop_front();
        check("resp_data", resp_data, mon_e.data);
        check("resp_err", {30'b0, resp_err}, {30'b0, mon_e.err});
      end
    end
  end

  initial begin
    #900_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // Target side: receive one word from stx, sampling near mid-bit.
  task automatic model_rx_word(output logic [31:0] w, output logic ok);
    int n;
    w  = '0;
    ok = 1'b1;
    for (int b = 0; b < 4; b++) begin
      n = 0;
      while (stx !== 1'b0 && n < 3000) begin
        @(negedge clk);
        n++;
      end
      if (stx !== 1'b0) begin
        check("stx_start_seen", {31'b0, stx}, 32'd0);
        ok = 1'b0;
        return;
      end
      repeat (DIV / 2) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
        repeat (DIV) @(negedge clk);
        w[8*b+i] = stx;
      end
      repeat (DIV) @(negedge clk);
    end
  endtask

  // Target side: send one word on srx; each byte is preceded by an idle bit.
  task automatic model_tx_word(input logic [31:0] w);
    for (int b = 0; b < 4; b++) begin
      srx = 1'b1;
      repeat (DIV) @(negedge clk);
      srx = 1'b0;
      repeat (DIV) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
        srx = w[8*b+i];
        repeat (DIV) @(negedge clk);
      end
      srx = 1'b1;
    end
  endtask

  task automatic wait_resp(output logic got);
    got = 1'b0;
    for (int n = 0; n < 3000 && !got; n++) begin
      @(negedge clk);
      if (resp_valid) got = 1'b1;
    end
  endtask

  task automatic run_txn(input logic [3:0] cmd, input logic [31:0] addr, input logic [31:0] data,
                         input logic [31:0] reply, input int corrupt, input logic hold);
    logic [31:0] words [3];
    logic [31:0] w;
    logic        ok;
    logic        got;
    exp_t        e;
    words[0] = {28'b0, cmd};
    words[1] = addr;
    words[2] = data;
    e.data = reply;
    e.err  = (corrupt >= 0) ? ERR_ECHO : ERR_OK;
    @(negedge clk);
    check("req_ready_before", {31'b0, req_ready}, 32'd1);
    req_valid = 1'b1;
    req_cmd   = cmd;
    req_addr  = addr;
    req_data  = data;
    sb.push_back(e);
    @(negedge clk);
    check("busy_after_accept", {31'b0, busy}, 32'd1);
    if (hold) begin
      req_cmd  = ~cmd;
      req_addr = ~addr;
      req_data = ~data;
    end else begin
      req_valid = 1'b0;
    end
    for (int i = 0; i < 3; i++) begin
      model_rx_word(w, ok);
      if (!ok) return;
      check($sformatf("tx_word%0d", i), w, words[i]);
      model_tx_word((i == corrupt) ? (w ^ 32'h1) : w);
    end
    model_tx_word(reply);
    wait_resp(got);
    req_valid = 1'b0;
    check("resp_seen", {31'b0, got}, 32'd1);
    @(negedge clk);
    check("ready_after_resp", {31'b0, req_ready}, 32'd1);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_req_ready"}, {31'b0, req_ready}, 32'd1);
    check({tag, "_busy"}, {31'b0, busy}, 32'd0);
    check({tag, "_resp_valid"}, {31'b0, resp_valid}, 32'd0);
    check({tag, "_resp_data"}, resp_data, 32'd0);
    check({tag, "_resp_err"}, {30'b0, resp_err}, 32'd0);
    check({tag, "_stx"}, {31'b0, stx}, 32'd1);
  endtask

  vec_t vecs [5];

  initial begin
    logic [31:0] w;
    logic        ok;
    logic        got;
    int          n;
    exp_t        e;

    vecs[0] = '{CMD_WRITE, 32'h0000_1000, 32'hDEAD_BEEF, 32'h1234_5678, -1};
    vecs[1] = '{CMD_WRITE, 32'h0000_1000, 32'hDEAD_BEEF, 32'hCAFE_F00D,  1};
    vecs[2] = '{CMD_READ,  32'h8000_0004, 32'h0000_0000, 32'hA5A5_5A5A,  0};
    vecs[3] = '{4'hF,      32'hFFFF_FFFF, 32'h0000_0001, 32'hFFFF_FFFF,  2};
    vecs[4] = '{CMD_HALT,  32'h0000_0000, 32'hFFFF_FFFF, 32'h0000_0000, -1};

    reset     = 1'b1;
    srx       = 1'b1;
    req_valid = 1'b0;
    req_cmd   = '0;
    req_addr  = '0;
    req_data  = '0;
    repeat (3) @(negedge clk);
    check_idle_outputs("in_reset");
    reset = 1'b0;
    @(negedge clk);
    check_idle_outputs("after_reset");

    for (int i = 0; i < 5; i++)
      run_txn(vecs[i].cmd, vecs[i].addr, vecs[i].data, vecs[i].reply, vecs[i].corrupt, 1'b0);

    // Timeout: target echoes cmd then goes silent. Latency from the addr
    // start bit = 40 bit times of addr + 1 cycle to see tx idle + TIMEOUT.
    @(negedge clk);
    req_valid = 1'b1;
    req_cmd   = CMD_READ;
    req_addr  = 32'h0000_2000;
    req_data  = 32'h0000_0055;
    e.data = 32'h0;
    e.err  = ERR_TIMEOUT;
    sb.push_back(e);
    @(negedge clk);
    req_valid = 1'b0;
    model_rx_word(w, ok);
    check("to_cmd_word", w, {28'b0, CMD_READ});
    model_tx_word(w);
    n = 0;
    while (stx !== 1'b0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    n = 0;
    got = 1'b0;
    while (!got && n < 3000) begin
      @(negedge clk);
      n++;
      if (resp_valid) got = 1'b1;
    end
    check("timeout_latency", n, 40 * DIV + 1 + TIMEOUT);
    @(negedge clk);
    check("timeout_ready_next", {31'b0, req_ready}, 32'd1);

    // Reset while the data word is on the line.
    @(negedge clk);
    req_valid = 1'b1;
    req_cmd   = CMD_WRITE;
    req_addr  = 32'h0000_1000;
    req_data  = 32'hDEAD_BEEF;
    @(negedge clk);
    req_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      model_rx_word(w, ok);
      model_tx_word(w);
    end
    n = 0;
    while (stx !== 1'b0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("data_start_seen", {31'b0, stx}, 32'd0);
    repeat (10) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check_idle_outputs("mid_reset");
    reset = 1'b0;
    repeat (300) @(negedge clk);
    run_txn(CMD_WRITE, 32'h0000_1000, 32'hDEAD_BEEF, 32'h0BAD_CAFE, -1, 1'b0);

    // req_valid held high with changing fields during a transaction.
    run_txn(CMD_WRITE, 32'h0000_3000, 32'h0F0F_0F0F, 32'h1111_2222, -1, 1'b1);
    repeat (20) @(negedge clk);
    check("held_not_requeued", {31'b0, busy}, 32'd0);

    // Spurious word from the target while idle.
    model_tx_word(32'h0BAD_F00D);
    repeat (50) @(negedge clk);
    check("spurious_ready", {31'b0, req_ready}, 32'd1);
    run_txn(CMD_RESUME, 32'h0000_4000, 32'h7777_8888, 32'h9999_AAAA, -1, 1'b0);

    repeat (20) @(negedge clk);
    check("scoreboard_empty", sb.size(), 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
